sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO; the next generation of the byte FIFO between the UART/IO circuits and the CPU's memory-mapped IO. It adds depth/width generality, occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a compile-time first-word-fall-through read mode.

## Interface
- data_width, 8: bits per entry.
- fifo_depth, 32: entries; power of two, ≥ 4.
- addr_width, $clog2(fifo_depth): storage index width.
- almost_full_thresh, fifo_depth-2: almost_full asserts at count ≥ this; range 1..fifo_depth.
- almost_empty_thresh, 2: almost_empty asserts at count ≤ this; range 0..fifo_depth-1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- din  in  data_width  write data.
- full  out  1  count == fifo_depth.
- almost_full  out  1  count ≥ almost_full_thresh.
- rd_en  in  1  read request (acknowledge in FWFT mode).
- dout  out  data_width  read data.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ almost_empty_thresh.
- count  out  addr_width+1  current occupancy, 0..fifo_depth.
- err_clr  in  1  clears overflow and underflow.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Pointers wr_ptr, rd_ptr are addr_width+1 bits; low bits index storage, MSB is the wrap bit; count = wr_ptr − rd_ptr (modulo 2^(addr_width+1)).
- Write accepted iff wr_en && !full; stores din at wr_ptr, wr_ptr+1.
- Read accepted iff rd_en && !empty; rd_ptr+1.
- full/empty are evaluated from registered state at the start of the cycle: write while full is rejected even with a simultaneous accepted read; read while empty is rejected even with a simultaneous accepted write.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Rejected write: storage and wr_ptr unchanged, overflow set. Rejected read: rd_ptr and dout unchanged, underflow set.
- err_clr clears both sticky flags; a new error event in the same cycle wins (flag stays 1).
- Flags and count are combinational decodes of registered pointers only; no input-to-output combinational path except as stated for FWFT dout.
- Reset (rst low, any time, including mid-burst): pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, dout 0. Storage contents are not reset.

## Timing
- Write at edge N: count, empty, almost_* reflect it after edge N (visible in cycle N+1).
- Standard mode: dout is registered; accepted read at edge N loads the head entry into dout at edge N; dout holds between reads.
- FWFT mode: dout = mem[rd_ptr] whenever !empty, 0 when empty; first write at edge N makes data valid in cycle N+1; rd_en pops the shown word at the next edge.
- Wrap-around: pointer low bits roll from fifo_depth−1 to 0; wrap bit toggles; full when low bits equal and wrap bits differ.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through read as above; dout has no register stage.
- Undefined: standard mode, registered dout, one-edge read latency.
- All flag, count and error behaviour is identical in both builds.

## Structure
- Shared package fifo_pkg: pointer-width derivation function and default threshold constants, reused by later async FIFO.
- Sub-module fifo_ram: fifo_depth × data_width register array, synchronous write port, asynchronous read port; sync_fifo wraps it with pointer, flag and output logic.

## Test plan
- Reset then idle: empty=1, almost_empty=1, full=0, count=0, dout=0, overflow=underflow=0.
- Write 0x01..0x20 (32 words, depth 32): count steps 1..32, almost_full at count 30, full at 32; read back all in order 0x01..0x20, empty at end.
- At full, wr_en=1 and rd_en=1 together with din=0xAA: read accepted, write rejected, count=31, overflow=1; err_clr pulse clears it.
- Read while empty: underflow=1, dout unchanged, count stays 0; err_clr and rd_en in same cycle leaves underflow=1.
- Wrap: 100 cycles of concurrent write/read with count held at 5; data order preserved across pointer wrap, count constant 5.
- Assert rst low mid-burst at count=17: all outputs return to reset values asynchronously; first write after release reads back correctly in both SYNC_FIFO_FWFT_EN builds.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer-width derivation and default flag thresholds.
// Reused by the single-clock FIFO and the later async FIFO.
package fifo_pkg;

  localparam int default_data_width     = 8;
  localparam int default_fifo_depth     = 32;
  localparam int default_af_margin      = 2;
  localparam int default_ae_thresh      = 2;

  // Pointer carries one extra wrap bit above the storage index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: register array with synchronous write and asynchronous read.
// Contents are intentionally not reset.
module fifo_ram #(
  parameter int data_width = 8,
  parameter int fifo_depth = 32,
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [fifo_depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered dout.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int data_width          = default_data_width,
  parameter int fifo_depth          = default_fifo_depth,
  parameter int addr_width          = ptr_width(fifo_depth) - 1,
  parameter int almost_full_thresh  = fifo_depth - default_af_margin,
  parameter int almost_empty_thresh = default_ae_thresh
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [data_width-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [addr_width:0] af_th   = (addr_width + 1)'(almost_full_thresh);
  localparam logic [addr_width:0] ae_th   = (addr_width + 1)'(almost_empty_thresh);
  localparam logic [addr_width:0] ptr_one = (addr_width + 1)'(1);

  logic [addr_width:0]   wr_ptr_q, rd_ptr_q;
  logic                  wr_accept, rd_accept;
  logic [data_width-1:0] rd_data;
  logic                  overflow_q, underflow_q;

  // Handshake: wr_en is a write request and !full its ready; a write transfers
  // only when both hold. Likewise rd_en with !empty. Rejected requests set the
  // sticky error flags instead of transferring.
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[addr_width] != rd_ptr_q[addr_width]) &&
                        (wr_ptr_q[addr_width-1:0] == rd_ptr_q[addr_width-1:0]);
  assign almost_full  = (count >= af_th);
  assign almost_empty = (count <= ae_th);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  fifo_ram #(
    .data_width (data_width),
    .fifo_depth (fifo_depth),
    .addr_width (addr_width)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_q[addr_width-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[addr_width-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + ptr_one;
      if (rd_accept) rd_ptr_q <= rd_ptr_q + ptr_one;
    end
  end

  // A fresh error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full)       overflow_q <= 1'b1;
      else if (err_clr)        overflow_q <= 1'b0;
      if (rd_en && empty)      underflow_q <= 1'b1;
      else if (err_clr)        underflow_q <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = empty ? '0 : rd_data;
`else
  logic [data_width-1:0] dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           dout_q <= '0;
    else if (rd_accept) dout_q <= rd_data;
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reference occupancy/flag model plus a data queue
// holding expected read order; works in both read-mode builds.
module tb_sync_fifo;

  localparam int dw    = 8;
  localparam int depth = 32;
  localparam int aw    = 5;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [dw-1:0] din;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [dw-1:0] dout;
  logic          empty;
  logic          almost_empty;
  logic [aw:0]   count;
  logic          err_clr;
  logic          overflow;
  logic          underflow;

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .dout         (dout),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [dw-1:0] exp_q[$];
  int            mdl_cnt;
  logic          mdl_ovf;
  logic          mdl_unf;
  logic [dw-1:0] last_dout;
  int            n_pass;
  int            n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    logic [dw-1:0] exp_dout;
`ifdef SYNC_FIFO_FWFT_EN
    exp_dout = (exp_q.size() == 0) ? '0 : exp_q[0];
`else
    exp_dout = last_dout;
`endif
    chk({tag, ".count"},        32'(count),        32'(mdl_cnt));
    chk({tag, ".empty"},        32'(empty),        32'(mdl_cnt == 0));
    chk({tag, ".full"},         32'(full),         32'(mdl_cnt == depth));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(mdl_cnt >= depth - 2));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(mdl_cnt <= 2));
    chk({tag, ".overflow"},     32'(overflow),     32'(mdl_ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(mdl_unf));
    chk({tag, ".dout"},         32'(dout),         32'(exp_dout));
  endtask

  // driver: one clock cycle of stimulus, model update, then state check
  task automatic step(input string tag, input logic wr, input logic [dw-1:0] d,
                      input logic rd, input logic clr);
    logic          acc_w, acc_r;
    logic [dw-1:0] popped;
    popped  = '0;
    wr_en   = wr;
    din     = d;
    rd_en   = rd;
    err_clr = clr;
    acc_w   = wr && (mdl_cnt != depth);
    acc_r   = rd && (mdl_cnt != 0);
    if (acc_r) begin
      popped = exp_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
      chk({tag, ".fwft_head"}, 32'(dout), 32'(popped));
`endif
    end
    if (acc_w) exp_q.push_back(d);
    @(posedge clk);
    #1;
    mdl_cnt = mdl_cnt + (acc_w ? 1 : 0) - (acc_r ? 1 : 0);
    if (wr && !acc_w)      mdl_ovf = 1'b1;
    else if (clr)          mdl_ovf = 1'b0;
    if (rd && !acc_r)      mdl_unf = 1'b1;
    else if (clr)          mdl_unf = 1'b0;
    if (acc_r) last_dout = popped;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    check_state(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_cnt   = 0;
    mdl_ovf   = 1'b0;
    mdl_unf   = 1'b0;
    last_dout = '0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    model_reset();
    rst     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_state("reset_idle");
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // fill with 0x01..0x20, then drain in order
    for (int i = 1; i <= depth; i++) step("fill_seq", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < depth; i++)  step("drain_seq", 1'b0, 8'h00, 1'b1, 1'b0);

    // refill, then write+read at full: read wins, write rejected
    for (int i = 0; i < depth; i++)
      step("fill_rand", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 8'hAA, 1'b1, 1'b0);
    step("ovf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    while (mdl_cnt > 0) step("drain_rand", 1'b0, 8'h00, 1'b1, 1'b0);

    // underflow, then clear racing a new underflow
    step("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);
    step("clr_and_rd_empty", 1'b0, 8'h00, 1'b1, 1'b1);
    step("unf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // pointer wrap with occupancy held at 5
    for (int i = 0; i < 5; i++) step("wrap_prime", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++)
      step("wrap_rw", 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    while (mdl_cnt > 0) step("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset mid-burst at count 17
    for (int i = 0; i < 17; i++) step("burst", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step("burst_err", 1'b0, 8'h00, 1'b0, 1'b0);
    wr_en = 1'b1;
    din   = 8'h33;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_state("async_reset");
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    check_state("reset_held");
    rst = 1'b1;
    step("post_reset_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
    step("post_reset_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
